// File: rtl/dmem_responder_if.sv
// Purpose : load/store request and response bundle between a CPU data port and dmem_responder.
// Latency : none (signal bundle only).
// Backpr. : requester holds req_valid until req_ready; responses are single-cycle strobes.
// Signals : req_valid/req_we/req_size/req_addr/req_wdata (requester -> memory),
//           req_ready/rsp_valid/rsp_rdata/rsp_err/busy (memory -> requester).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose : single-port data memory answering RISC-V style b/h/w loads and stores.
// Latency : response strobe WAIT_CYCLES+1 cycles after the accept edge; one request per WAIT_CYCLES+2 cycles.
// Backpr. : req_ready only in IDLE; requests outside IDLE are ignored and busy stalls the pipeline.
// Ports   : clk, reset (synchronous, active-high), bus (dmem_responder_if.slave).
// Config  : define DMEM_MISALIGN_CHECK_EN to flag misaligned h/hu/w accesses via rsp_err
//           (write suppressed, rdata 0); otherwise h/hu/w are aligned down and rsp_err is 0.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic              we_q;
    logic [2:0]        size_q;
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic accept;
    logic enter_resp;

    // Current access: straight from the request port when RESP is entered
    // directly from IDLE (WAIT_CYCLES = 0), otherwise from the latched copy.
    logic              acc_we;
    logic [2:0]        acc_size;
    logic [IDX_W+1:0]  acc_addr;
    logic [31:0]       acc_wdata;
    logic [IDX_W-1:0]  idx;

    logic        is_byte, is_half, misalign;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] raw, load_val;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Upper address bits alias onto the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:IDX_W+2];

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                // cnt_q counts the WAIT cycles still to go, this one included;
                // the edge that takes it to zero is the edge into RESP.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
    end

    // Reset forces state_d to IDLE, so an aborted transaction never reaches memory.
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    assign acc_we    = (state_q == IDLE) ? bus.req_we                : we_q;
    assign acc_size  = (state_q == IDLE) ? bus.req_size              : size_q;
    assign acc_addr  = (state_q == IDLE) ? bus.req_addr[IDX_W+1:0]   : addr_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata             : wdata_q;
    assign idx       = acc_addr[IDX_W+1:2];

    // size[1:0] picks width; 011/110/111 fall into the word class.
    assign is_byte = (acc_size[1:0] == 2'b00);
    assign is_half = (acc_size[1:0] == 2'b01);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (is_half && acc_addr[0]) ||
                      (!is_byte && !is_half && (acc_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        byte_en = 4'b1111;
        wr_data = acc_wdata;
        if (is_byte) begin
            byte_en = 4'b0001 << acc_addr[1:0];
            wr_data = {4{acc_wdata[7:0]}};
        end else if (is_half) begin
            byte_en = acc_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{acc_wdata[15:0]}};
        end
    end

    assign raw = mem[idx];

    always_comb begin
        sel_byte = raw[7:0];
        case (acc_addr[1:0])
            2'd0:    sel_byte = raw[7:0];
            2'd1:    sel_byte = raw[15:8];
            2'd2:    sel_byte = raw[23:16];
            default: sel_byte = raw[31:24];
        endcase
        sel_half = acc_addr[1] ? raw[31:16] : raw[15:0];

        load_val = raw;
        case (acc_size)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_val = {24'd0, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                rdata_q <= (acc_we || misalign) ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[IDX_W+1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // Memory has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP) && !reset;
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : 32'd0;
    assign bus.busy      = (state_q != IDLE) && !reset;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= misalign;
        end
    end
    assign bus.rsp_err = bus.rsp_valid && err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, extra response wait states (legal range 0..7).
REQ-003 clk  input  1  rising-edge clock; one clock domain only.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  request may be accepted this cycle.
REQ-011 rsp_valid  output  1  single-cycle response strobe.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-013 rsp_err  output  1  misaligned-access error, qualified by rsp_valid.
REQ-014 busy  output  1  transaction in flight; stall request to hazard unit.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE with reset low; accept = req_valid && req_ready.
REQ-017 On accept, the block SHALL latch we/size/addr/wdata, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP directly if WAIT_CYCLES = 0.
REQ-018 In WAIT the counter SHALL decrement each cycle; on the edge where it reads 0, the FSM SHALL go to RESP.
REQ-019 The memory access (read sample, store write) SHALL occur on the edge entering RESP.
REQ-020 rsp_valid SHALL be high for exactly the RESP cycle, WAIT_CYCLES+1 cycles after the accept edge; RESP SHALL always return to IDLE.
REQ-021 busy SHALL equal (state != IDLE) and needs no extra flop.
REQ-022 req_valid outside IDLE SHALL be ignored; back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-023 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored (aliasing wrap).
REQ-024 Byte stores SHALL write lane addr[1:0] with wdata[7:0]; halfword stores SHALL write lanes addr[1]*2..+1 with wdata[15:0]; other lanes unchanged.
REQ-025 Loads b/h SHALL sign-extend, bu/hu SHALL zero-extend the selected lane(s); w SHALL return the full word.
REQ-026 Undefined req_size codes (011, 110, 111) SHALL be treated as w.
REQ-027 A load from an address stored in an earlier completed transaction SHALL return the new data (no stale read).

Reset
REQ-028 While reset is high: state = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
REQ-029 Reset in WAIT SHALL abort the transaction; a pending store SHALL NOT be written and no response SHALL be issued.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHECK_EN SHALL select misalignment checking.
REQ-032 Defined: h/hu with addr[0] = 1, or w with addr[1:0] != 0, SHALL suppress the write, return rsp_rdata = 0 and rsp_err = 1 in RESP, with unchanged latency.
REQ-033 Undefined: rsp_err SHALL be tied 0; h/hu SHALL ignore addr[0] and w SHALL ignore addr[1:0] (aligned down).

Verification
REQ-034 WAIT_CYCLES = 1: sw 0xDEADBEEF to 0x10, then lw 0x10 -> each rsp_valid 2 cycles after accept; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-035 After REQ-034: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-036 sb 0x11 with wdata 0x000000AA over 0xDEADBEEF, then lw 0x10 -> 0xDEADAABF... corrected expectation 0xDEADAAEF.
REQ-037 Assert reset in WAIT of sw 0x1234 to 0x20 -> no rsp_valid, busy = 0 next cycle; lw 0x20 returns prior contents.
REQ-038 Macro defined: lw 0x22 -> rsp_err = 1, rsp_rdata = 0; sw 0x22 leaves word 0x20 unchanged. Macro undefined: lw 0x22 returns word 0x20, rsp_err = 0.
REQ-039 WAIT_CYCLES = 0, DEPTH_WORDS = 1024: sw 0x5 to 0x1000 then lw 0x0 -> 0x5 (wrap), rsp_valid 1 cycle after accept, req_ready low for exactly 1 cycle.
